// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: IF-stage fetch queue, in-order imem requests, DEPTH-entry FIFO.
// Optional macro FETCH_BYPASS_EN: same-cycle response bypass to ID when the FIFO is empty.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_add4_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        overflow_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W:0]   CREDIT = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_add4;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop_cnt;
    logic [31:0]       fetch_pc;
    logic [31:0]       resp_pc;
    logic [31:0]       target;

    logic head_valid;
    logic rsp_ok;
    logic consume;
    logic push;
    logic pop;
    logic full_drop;
    logic wr_en;
    logic fire;
    logic rsp_dec;

    // Handshake decode, credit check and output selection
    always_comb begin
        target      = redirect_pc_i & ~32'h3;
        head_valid  = (count != '0);
        imem_req_o  = !rst_i && !redirect_i &&
                      (({1'b0, count} + {1'b0, outstanding}) < CREDIT);
        imem_addr_o = fetch_pc;
        fire        = imem_req_o && imem_ready_i;
        rsp_dec     = imem_rvalid_i && (outstanding != '0);
        rsp_ok      = !rst_i && !redirect_i && imem_rvalid_i &&
                      (drop_cnt == '0);
        consume     = 1'b0;
        instr_valid_o = head_valid;
        instr_o       = head_valid ? mem[rd_ptr].instr : 32'h0;
        pc_add4_o     = head_valid ? mem[rd_ptr].pc_add4 : 32'h0;
`ifdef FETCH_BYPASS_EN
        if (!head_valid && rsp_ok) begin
            instr_valid_o = 1'b1;
            instr_o       = imem_rdata_i;
            pc_add4_o     = resp_pc + 32'd4;
            consume       = !stall_i;
        end
`endif
        push      = rsp_ok && !consume;
        pop       = head_valid && !stall_i && !redirect_i;
        full_drop = push && (count == FULL) && !pop;
        wr_en     = push && !full_drop;
    end

    // FIFO storage, written only on an accepted push
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= '{instr: imem_rdata_i, pc_add4: resp_pc + 32'd4};
        end
    end

    // Control state: pointers, counters, PCs, drop accounting, sticky overflow
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            overflow_o  <= 1'b0;
        end else if (redirect_i) begin
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fetch_pc    <= target;
            resp_pc     <= target;
            drop_cnt    <= outstanding - CNT_W'(rsp_dec);
            outstanding <= outstanding - CNT_W'(rsp_dec);
        end else begin
            if (fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (fire && !rsp_dec) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (!fire && rsp_dec) begin
                outstanding <= outstanding - CNT_W'(1);
            end
            if (imem_rvalid_i) begin
                if (drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end else begin
                    resp_pc <= resp_pc + 32'd4;
                end
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_en && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !wr_en) begin
                count <= count - CNT_W'(1);
            end
            if (full_drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Front end of the pipelined CPU. Replaces the bare PC/adder/instruction-memory path in the IF stage and feeds the IF/ID pipeline register.
- Issues in-order fetch requests to an instruction memory with variable latency and buffers returned instructions with their PC+4 in a DEPTH-entry FIFO.
- Presents one instruction per cycle to ID under a valid/stall handshake.
- On a taken branch (PCSrc from MEM) it flushes buffered and in-flight fetches and restarts at the target.

Parameters:
DEPTH, 4, FIFO entries and maximum in-flight requests; power of two, 2..16
RESET_PC, 32'h0000_0000, first fetch address after reset
CNT_W, 3, width of the occupancy and outstanding counters; must hold 0..DEPTH (i.e. clog2(DEPTH)+1)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-high
redirect_i  in  1  taken branch from MEM stage; flush and refetch
redirect_pc_i  in  32  branch target, valid with redirect_i
stall_i  in  1  ID stage cannot accept this cycle
instr_valid_o  out  1  instr_o/pc_add4_o hold a valid instruction
instr_o  out  32  instruction at FIFO head; 32'h0 (NOP) when invalid
pc_add4_o  out  32  PC+4 of instr_o; 32'h0 when invalid
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address (word aligned)
imem_ready_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  response valid, strictly in request order, latency >= 1
imem_rdata_i  in  32  response instruction
overflow_o  out  1  sticky: response arrived with FIFO full

Behaviour:
- Reset (async assert):
  - fetch_pc = resp_pc = RESET_PC.
  - count, outstanding and drop_cnt = 0.
  - instr_valid_o = 0, instr_o = 0, pc_add4_o = 0, imem_req_o = 0, imem_addr_o = RESET_PC, overflow_o = 0.
- Any redirect, request or response in the reset cycle is ignored.
- Issue:
  - imem_req_o = !rst_i && !redirect_i && (count + outstanding < DEPTH).
  - imem_addr_o = fetch_pc.
  - Handshake when imem_req_o && imem_ready_i: fetch_pc += 4 (32-bit wrap at 32'hFFFF_FFFC -> 0) and outstanding increments.
- Response (imem_rvalid_i):
  - outstanding decrements.
  - If drop_cnt > 0: discard and decrement drop_cnt.
  - Otherwise push {imem_rdata_i, resp_pc+4} and set resp_pc += 4.
  - A push with count == DEPTH and no pop that cycle discards the data and sets overflow_o.
- Issue and response in the same cycle: outstanding is unchanged.
- Output:
  - Registered FIFO head; instr_valid_o = (count != 0).
  - Pop when instr_valid_o && !stall_i && !redirect_i.
  - Push and pop in the same cycle leave count unchanged.
  - Default latency: a response is visible on instr_o the cycle after imem_rvalid_i.
  - While stalled, outputs hold stable.
- Redirect (priority over stall, issue and push):
  - count <= 0 (FIFO flushed, no pop).
  - fetch_pc <= redirect_pc_i; resp_pc <= redirect_pc_i.
  - drop_cnt <= outstanding - imem_rvalid_i; any response in the redirect cycle is discarded.
  - outstanding <= outstanding - imem_rvalid_i.
  - imem_req_o is 0 in the redirect cycle. First request to the target is issued the next cycle, subject to credit.
- Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- redirect_pc_i[1:0] is ignored (forced to 0).

Optional Feature:
FETCH_BYPASS_EN:
- Defined: when count == 0 and a non-dropped response arrives (no redirect), instr_o/pc_add4_o/instr_valid_o present it combinationally in the same cycle.
  - If !stall_i it is consumed without being written to the FIFO.
  - If stall_i it is pushed as normal.
- Undefined: no combinational path from imem_* to the output ports; minimum response-to-output latency is 1 cycle.

Test Plan:
- Reset, memory latency 1, stall_i = 0 -> requests at 0x0, 0x4, 0x8 on consecutive cycles; instr_valid_o rises 2 cycles after the first request; pc_add4_o = 0x4, 0x8, 0xC in order, one per cycle.
- Hold stall_i = 1 with memory latency 1 -> FIFO fills to 4; imem_req_o drops once count+outstanding = 4; outputs hold the 0x0 instruction; release stall -> 4 pops, fetching resumes at 0x10.
- Latency 3, 3 requests in flight, redirect_i with redirect_pc_i = 0x100 -> instr_valid_o = 0 next cycle; the 3 stale responses are discarded; next valid output has pc_add4_o = 0x104 and the data returned for address 0x100.
- Redirect in the same cycle as a response and stall_i = 1 -> that response is discarded; drop_cnt = outstanding-1; no pop; fetch restarts at target.
- Memory returns a spurious rvalid with FIFO full -> overflow_o = 1 and stays 1 until rst_i; FIFO contents unchanged.
- Assert rst_i asynchronously mid-burst -> all outputs are at reset values before the next clock edge; after release the first request is at RESET_PC.
